// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: show-ahead read port between the receive FIFO and the core
interface uart_rx_fifo_if;
    logic       uart_rdreq;
    logic       uart_empty;
    logic       uart_full;
    logic [7:0] uart_in;
    modport master (output uart_rdreq, input uart_empty, input uart_full, input uart_in);
    modport slave  (input uart_rdreq, output uart_empty, output uart_full, output uart_in);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO with overrun/framing pulses
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rxd_i,
    uart_rx_fifo_if.slave  rd,
    output logic           frame_err_o,
    output logic           overrun_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic                rxd_m_q, rxd_s_q, rxd_p_q;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bi_q, bi_d;
    logic [7:0]          sh_q, sh_d;
    logic                push, ferr;
    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_q, rd_q;
    logic                empty, full, pop, wr_en;
    logic                frame_err_q, overrun_q;
    // rxd_p_q holds the previous synchronised level so IDLE only starts on a real 1->0 edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m_q <= 1'b1;
            rxd_s_q <= 1'b1;
            rxd_p_q <= 1'b1;
        end else begin
            rxd_m_q <= rxd_i;
            rxd_s_q <= rxd_m_q;
            rxd_p_q <= rxd_s_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bi_q    <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bi_q    <= bi_d;
            sh_q    <= sh_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bi_d    = bi_q;
        sh_d    = sh_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s_q && rxd_p_q) state_d = START;
            end
            START: if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                cnt_d   = '0;
                bi_d    = '0;
                state_d = rxd_s_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d       = '0;
                sh_d[bi_q]  = rxd_s_q;
                bi_d        = bi_q + 3'd1;
                state_d     = (bi_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d   = '0;
                state_d = IDLE;
                push    = rxd_s_q;
                ferr    = !rxd_s_q;
            end
            default: state_d = IDLE;
        endcase
    end
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                   (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
    assign pop   = rd.uart_rdreq && !empty;
    // a pop in the same edge frees the slot, so a full FIFO still accepts the byte
    assign wr_en = push && (!full || pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (wr_en) mem_q[wr_q[DEPTH_LOG2-1:0]] <= sh_q;
            wr_q        <= wr_en ? wr_q + 1'b1 : wr_q;
            rd_q        <= pop ? rd_q + 1'b1 : rd_q;
            frame_err_q <= ferr;
            overrun_q   <= push && full && !pop;
        end
    end
    assign rd.uart_empty = empty;
    assign rd.uart_full  = full;
    assign rd.uart_in    = mem_q[rd_q[DEPTH_LOG2-1:0]];
    assign frame_err_o   = frame_err_q;
    assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table plus corner sequences for the UART receive FIFO
module tb_uart_rx_fifo;
    localparam int CPB = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic frame_err, overrun;
    int   pass_cnt = 0, total_cnt = 0;
    int   fe_cnt = 0, ov_cnt = 0;
    uart_rx_fifo_if rd ();
    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .rxd_i(rxd), .rd(rd),
        .frame_err_o(frame_err), .overrun_o(overrun)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end
    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_empty;
        logic [7:0] exp_in;
        int         exp_fe;
    } vec_t;
    vec_t vt [6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask
    task automatic align();
        @(posedge clk);
        #1;
    endtask
    task automatic bit_out(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        rxd = 1'b1;
    endtask
    task automatic tx(input logic [7:0] b, input logic stop);
        align();
        send(b, stop);
        repeat (4) @(posedge clk);
        #1;
    endtask
    task automatic pop_one();
        rd.uart_rdreq = 1'b1;
        @(posedge clk);
        #1;
        rd.uart_rdreq = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        int n, fe0, ov0;
        rd.uart_rdreq = 1'b0;
        vt[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 0};
        vt[1] = '{8'h3C, 1'b0, 1'b1, 8'h00, 1};
        vt[2] = '{8'h01, 1'b1, 1'b0, 8'h01, 0};
        vt[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 0};
        vt[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 0};
        vt[5] = '{8'h5A, 1'b0, 1'b1, 8'h00, 1};
        repeat (3) @(negedge clk);
        chk("rst_empty", rd.uart_empty, 1);
        chk("rst_full", rd.uart_full, 0);
        chk("rst_in", rd.uart_in, 8'h00);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // first-byte latency from the rxd falling edge
        align();
        n = 0;
        fork
            send(8'hA5, 1'b1);
            begin
                while (n < 400) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (!rd.uart_empty) break;
                end
            end
        join
        chk("latency", n, 155);
        chk("lat_in", rd.uart_in, 8'hA5);
        pop_one();
        chk("lat_pop_empty", rd.uart_empty, 1);
        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            tx(vt[i].data, vt[i].stop);
            @(negedge clk);
            chk($sformatf("v%0d_empty", i), rd.uart_empty, vt[i].exp_empty);
            chk($sformatf("v%0d_ferr", i), fe_cnt - fe0, vt[i].exp_fe);
            chk($sformatf("v%0d_ovr", i), ov_cnt - ov0, 0);
            if (!vt[i].exp_empty) begin
                chk($sformatf("v%0d_in", i), rd.uart_in, vt[i].exp_in);
                pop_one();
                chk($sformatf("v%0d_pop_empty", i), rd.uart_empty, 1);
            end
        end
        // short low glitch is rejected without a frame error
        fe0 = fe_cnt;
        align();
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_empty", rd.uart_empty, 1);
        chk("glitch_ferr", fe_cnt - fe0, 0);
        tx(8'h96, 1'b1);
        @(negedge clk);
        chk("post_glitch_in", rd.uart_in, 8'h96);
        pop_one();
        // a held-low break gives exactly one frame error
        fe0 = fe_cnt;
        align();
        rxd = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        chk("break_ferr", fe_cnt - fe0, 1);
        chk("break_empty", rd.uart_empty, 1);
        // overflow: fifth byte dropped
        for (int i = 0; i < 4; i++) tx(8'h10 + 8'(i), 1'b1);
        @(negedge clk);
        chk("ovf_full", rd.uart_full, 1);
        ov0 = ov_cnt;
        tx(8'h14, 1'b1);
        @(negedge clk);
        chk("ovf_pulse", ov_cnt - ov0, 1);
        chk("ovf_still_full", rd.uart_full, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), rd.uart_in, 8'h10 + 8'(i));
            pop_one();
        end
        chk("drain_empty", rd.uart_empty, 1);
        // push and pop on the same edge while full
        for (int i = 0; i < 4; i++) tx(8'h20 + 8'(i), 1'b1);
        ov0 = ov_cnt;
        align();
        fork
            send(8'h24, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                chk("coin_full_before", rd.uart_full, 1);
                rd.uart_rdreq = 1'b1;
                @(posedge clk);
                #1;
                rd.uart_rdreq = 1'b0;
            end
        join
        @(negedge clk);
        chk("coin_ovr", ov_cnt - ov0, 0);
        chk("coin_full", rd.uart_full, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("coin_drain%0d", i), rd.uart_in, 8'h21 + 8'(i));
            pop_one();
        end
        chk("coin_empty", rd.uart_empty, 1);
        // async reset in the middle of a frame
        tx(8'h77, 1'b1);
        align();
        fork
            send(8'hFF, 1'b1);
            begin
                repeat (4 * CPB + 8) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("mid_rst_empty", rd.uart_empty, 1);
                chk("mid_rst_in", rd.uart_in, 8'h00);
                chk("mid_rst_full", rd.uart_full, 0);
                chk("mid_rst_ferr", frame_err, 0);
                chk("mid_rst_ovr", overrun, 0);
                #10 rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("post_rst_empty", rd.uart_empty, 1);
        tx(8'h5A, 1'b1);
        @(negedge clk);
        chk("post_rst_in", rd.uart_in, 8'h5A);
        pop_one();
        chk("post_rst_pop_empty", rd.uart_empty, 1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
